axis_frame_fifo_sc: RTL and testbench

//  Single-clock AXI-Stream FIFO for app datapaths. Successor to the CDC stream FIFO, with optional frame
//  (store-and-forward) mode and bad-frame/overflow dropping, plus registered output and status counters.

---
 rtl/axis_frame_fifo_sc_pkg.sv | 16 +
 rtl/axis_frame_fifo_sc_ram.sv | 24 ++
 rtl/axis_frame_fifo_sc.sv | 171 +++++++++++++++++
 tb/tb_axis_frame_fifo_sc.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_frame_fifo_sc_pkg.sv
// Shared types and helpers for the single-clock AXI-Stream frame FIFO.
package axis_frame_fifo_sc_pkg;

    typedef enum logic {
        WR_PASS = 1'b0,
        WR_DROP = 1'b1
    } wr_state_e;

    // Width of one stored beat, packed as {data, keep, last, id, dest, user}.
    function automatic int axis_word_width(input int data_w, input int keep_w,
                                           input int id_w, input int dest_w,
                                           input int user_w);
        return data_w + keep_w + 1 + id_w + dest_w + user_w;
    endfunction

endpackage

// File: rtl/axis_frame_fifo_sc_ram.sv
// Simple dual-port RAM: one write port, one read port with registered read data.
module axis_frame_fifo_sc_ram #(
    parameter int WIDTH = 8,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [2**AW];

    // NOTE: storage and its read register carry no reset so they map onto block RAM;
    // validity is tracked by the pointers in the parent, never by the contents.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/axis_frame_fifo_sc.sv
// Single-clock AXI-Stream FIFO with optional store-and-forward frame mode,
// bad-frame / overflow dropping, registered output and status counters.
module axis_frame_fifo_sc
    import axis_frame_fifo_sc_pkg::*;
#(
    parameter int DATA_WIDTH     = 64,
    parameter int KEEP_ENABLE    = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH     = (DATA_WIDTH + 7) / 8,
    parameter int ID_WIDTH       = 8,
    parameter int DEST_WIDTH     = 8,
    parameter int USER_WIDTH     = 1,
    parameter int USER_BAD_BIT   = 0,
    parameter int DEPTH          = 4096,
    parameter int FRAME_FIFO     = 0,
    parameter int DROP_BAD_FRAME = 0,
    parameter int DROP_WHEN_FULL = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]     s_axis_tkeep,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    input  logic                      s_axis_tlast,
    input  logic [ID_WIDTH-1:0]       s_axis_tid,
    input  logic [DEST_WIDTH-1:0]     s_axis_tdest,
    input  logic [USER_WIDTH-1:0]     s_axis_tuser,
    output logic [DATA_WIDTH-1:0]     m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]     m_axis_tkeep,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic                      m_axis_tlast,
    output logic [ID_WIDTH-1:0]       m_axis_tid,
    output logic [DEST_WIDTH-1:0]     m_axis_tdest,
    output logic [USER_WIDTH-1:0]     m_axis_tuser,
    output logic [$clog2(DEPTH):0]    status_depth,
    output logic                      status_overflow,
    output logic                      status_bad_frame,
    output logic                      status_good_frame
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int W  = axis_word_width(DATA_WIDTH, KEEP_WIDTH, ID_WIDTH, DEST_WIDTH, USER_WIDTH);

    localparam bit FRAME_EN    = (FRAME_FIFO != 0);
    localparam bit DROP_FULL   = FRAME_EN && (DROP_WHEN_FULL != 0);
    localparam bit DROP_BAD    = FRAME_EN && (DROP_BAD_FRAME != 0);
    localparam logic [PW-1:0] FULL_CNT = PW'(DEPTH);

    wr_state_e     state, state_n;
    logic [PW-1:0] wr_ptr_cur, wr_ptr_cur_n, wr_ptr_commit, wr_ptr_commit_n;
    logic [PW-1:0] rd_ptr, rd_ptr_out;
    logic          good_n, bad_n, ovf_n, we;

    // rd_ptr_out retires beats only when they leave the output register, so the
    // two beats prefetched into the read pipeline still count as occupied.
    logic full, empty, too_big, drop_ok, s_hs, bad_in;
    assign full    = (wr_ptr_cur - rd_ptr_out) == FULL_CNT;
    assign empty   = rd_ptr == wr_ptr_commit;
    assign too_big = FRAME_EN && ((wr_ptr_cur - wr_ptr_commit) == FULL_CNT);
    assign drop_ok = DROP_FULL || too_big;
    assign s_axis_tready = !rst && (state == WR_DROP || !full || drop_ok);
    assign s_hs    = s_axis_tvalid && s_axis_tready;
    assign bad_in  = DROP_BAD && s_axis_tuser[USER_BAD_BIT];

    logic [KEEP_WIDTH-1:0] keep_in;
    logic [W-1:0]          wr_word, ram_q, out_word;
    assign keep_in = (KEEP_ENABLE != 0) ? s_axis_tkeep : {KEEP_WIDTH{1'b1}};
    assign wr_word = {s_axis_tdata, keep_in, s_axis_tlast, s_axis_tid, s_axis_tdest, s_axis_tuser};

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_n         = state;
        wr_ptr_cur_n    = wr_ptr_cur;
        wr_ptr_commit_n = wr_ptr_commit;
        we              = 1'b0;
        good_n          = 1'b0;
        bad_n           = 1'b0;
        ovf_n           = 1'b0;
        if (s_hs) begin
            if (state == WR_DROP) begin
                if (s_axis_tlast) begin
                    ovf_n   = 1'b1;
                    state_n = WR_PASS;
                end
            end else if (full) begin
                wr_ptr_cur_n = wr_ptr_commit;
                if (s_axis_tlast) ovf_n = 1'b1;
                else              state_n = WR_DROP;
            end else begin
                we           = 1'b1;
                wr_ptr_cur_n = wr_ptr_cur + 1'b1;
                if (!FRAME_EN) wr_ptr_commit_n = wr_ptr_cur + 1'b1;
                if (s_axis_tlast) begin
                    if (bad_in) begin
                        wr_ptr_cur_n = wr_ptr_commit;
                        bad_n        = 1'b1;
                    end else begin
                        wr_ptr_commit_n = wr_ptr_cur + 1'b1;
                        good_n          = 1'b1;
                    end
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= WR_PASS;
            wr_ptr_cur        <= '0;
            wr_ptr_commit     <= '0;
            status_good_frame <= 1'b0;
            status_bad_frame  <= 1'b0;
            status_overflow   <= 1'b0;
        end else begin
            state             <= state_n;
            wr_ptr_cur        <= wr_ptr_cur_n;
            wr_ptr_commit     <= wr_ptr_commit_n;
            status_good_frame <= good_n;
            status_bad_frame  <= bad_n;
            status_overflow   <= ovf_n;
        end
    end

    // Read pipeline: RAM read register (stage 1) feeding the output register (stage 2).
    logic ram_valid, out_valid, load_out, rd_en, m_hs;
    assign load_out = ram_valid && (!out_valid || m_axis_tready);
    assign rd_en    = !empty && (!ram_valid || load_out);
    assign m_hs     = out_valid && m_axis_tready;

    axis_frame_fifo_sc_ram #(.WIDTH(W), .AW(AW)) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (wr_ptr_cur[AW-1:0]),
        .wdata (wr_word),
        .re    (rd_en),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (ram_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr       <= '0;
            rd_ptr_out   <= '0;
            ram_valid    <= 1'b0;
            out_valid    <= 1'b0;
            out_word     <= '0;
            status_depth <= '0;
        end else begin
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            if (m_hs)  rd_ptr_out <= rd_ptr_out + 1'b1;
            if (rd_en)         ram_valid <= 1'b1;
            else if (load_out) ram_valid <= 1'b0;
            // Sidebands return to zero whenever the output register empties.
            if (load_out) begin
                out_valid <= 1'b1;
                out_word  <= ram_q;
            end else if (m_hs) begin
                out_valid <= 1'b0;
                out_word  <= '0;
            end
            status_depth <= wr_ptr_cur - rd_ptr_out;
        end
    end

    assign m_axis_tvalid = out_valid;
    assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tid, m_axis_tdest, m_axis_tuser} = out_word;

endmodule

// File: tb/tb_axis_frame_fifo_sc.sv
// Bench for axis_frame_fifo_sc: instance 0 is a plain FIFO, instance 1 a frame FIFO
// that drops bad frames and frames that do not fit.
module tb_axis_frame_fifo_sc;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic [7:0]  id;
        logic [7:0]  dest;
        logic [0:0]  user;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] s_tdata [2];
    logic [7:0]  s_tkeep [2];
    logic        s_tvalid [2];
    logic        s_tready [2];
    logic        s_tlast [2];
    logic [7:0]  s_tid [2];
    logic [7:0]  s_tdest [2];
    logic [0:0]  s_tuser [2];
    logic [63:0] m_tdata [2];
    logic [7:0]  m_tkeep [2];
    logic        m_tvalid [2];
    logic        m_tready [2];
    logic        m_tlast [2];
    logic [7:0]  m_tid [2];
    logic [7:0]  m_tdest [2];
    logic [0:0]  m_tuser [2];
    logic [4:0]  st_depth [2];
    logic        st_ovf [2];
    logic        st_bad [2];
    logic        st_good [2];

    always #5 clk = ~clk;

    axis_frame_fifo_sc #(.DATA_WIDTH(64), .DEPTH(16), .FRAME_FIFO(0)) dut0 (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata[0]), .s_axis_tkeep(s_tkeep[0]), .s_axis_tvalid(s_tvalid[0]),
        .s_axis_tready(s_tready[0]), .s_axis_tlast(s_tlast[0]), .s_axis_tid(s_tid[0]),
        .s_axis_tdest(s_tdest[0]), .s_axis_tuser(s_tuser[0]),
        .m_axis_tdata(m_tdata[0]), .m_axis_tkeep(m_tkeep[0]), .m_axis_tvalid(m_tvalid[0]),
        .m_axis_tready(m_tready[0]), .m_axis_tlast(m_tlast[0]), .m_axis_tid(m_tid[0]),
        .m_axis_tdest(m_tdest[0]), .m_axis_tuser(m_tuser[0]),
        .status_depth(st_depth[0]), .status_overflow(st_ovf[0]),
        .status_bad_frame(st_bad[0]), .status_good_frame(st_good[0])
    );

    axis_frame_fifo_sc #(.DATA_WIDTH(64), .DEPTH(16), .FRAME_FIFO(1),
                         .DROP_BAD_FRAME(1), .DROP_WHEN_FULL(1)) dut1 (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata[1]), .s_axis_tkeep(s_tkeep[1]), .s_axis_tvalid(s_tvalid[1]),
        .s_axis_tready(s_tready[1]), .s_axis_tlast(s_tlast[1]), .s_axis_tid(s_tid[1]),
        .s_axis_tdest(s_tdest[1]), .s_axis_tuser(s_tuser[1]),
        .m_axis_tdata(m_tdata[1]), .m_axis_tkeep(m_tkeep[1]), .m_axis_tvalid(m_tvalid[1]),
        .m_axis_tready(m_tready[1]), .m_axis_tlast(m_tlast[1]), .m_axis_tid(m_tid[1]),
        .m_axis_tdest(m_tdest[1]), .m_axis_tuser(m_tuser[1]),
        .status_depth(st_depth[1]), .status_overflow(st_ovf[1]),
        .status_bad_frame(st_bad[1]), .status_good_frame(st_good[1])
    );

    int     n_checks = 0;
    int     n_err = 0;
    int     seq = 0;
    beat_t  exp_q [2][$];
    int     good_cnt [2] = '{0, 0};
    int     bad_cnt [2] = '{0, 0};
    int     ovf_cnt [2] = '{0, 0};
    longint first_t [2] = '{0, 0};
    longint last_t [2] = '{0, 0};
    beat_t  mon_got, mon_exp;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic beat_t mk_beat(input logic [63:0] d, input logic l, input logic u);
        beat_t b;
        b.data = d;
        b.keep = d[7:0];
        b.last = l;
        b.id   = d[7:0] ^ 8'h5A;
        b.dest = d[15:8];
        b.user = u;
        return b;
    endfunction

    // Scoreboard side: every egress handshake pops one expected beat.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                if (st_good[i]) good_cnt[i]++;
                if (st_bad[i])  bad_cnt[i]++;
                if (st_ovf[i])  ovf_cnt[i]++;
                if (m_tvalid[i] && first_t[i] == 0) first_t[i] = $time;
                if (m_tvalid[i] && m_tready[i]) begin
                    mon_got = {m_tdata[i], m_tkeep[i], m_tlast[i], m_tid[i], m_tdest[i], m_tuser[i]};
                    last_t[i] = $time;
                    if (exp_q[i].size() == 0) begin
                        check($sformatf("extra_beat%0d", i), 96'(mon_got), 96'(0));
                    end else begin
                        mon_exp = exp_q[i].pop_front();
                        check($sformatf("beat%0d", i), 96'(mon_got), 96'(mon_exp));
                    end
                end
            end
        end
    end

    task automatic drive(input int i, input logic l, input logic u, input bit push);
        beat_t b;
        seq++;
        b = mk_beat(64'hC0DE_0000_0000_0000 | (64'(i) << 40) | 64'(seq), l, u);
        s_tdata[i]  = b.data;
        s_tkeep[i]  = b.keep;
        s_tlast[i]  = l;
        s_tid[i]    = b.id;
        s_tdest[i]  = b.dest;
        s_tuser[i]  = u;
        s_tvalid[i] = 1'b1;
        if (push) exp_q[i].push_back(b);
    endtask

    task automatic wait_hs(input int i, output longint t_hs, output int waits);
        logic ok;
        waits = 0;
        forever begin
            @(negedge clk);
            ok = s_tready[i];
            @(posedge clk);
            if (ok) break;
            waits++;
            if (waits > 400) begin
                check($sformatf("send_timeout%0d", i), 96'(ok), 96'(1));
                break;
            end
        end
        t_hs = $time;
        #1;
    endtask

    task automatic send(input int i, input logic l, input logic u, input bit push,
                        output longint t_hs, output int waits);
        drive(i, l, u, push);
        wait_hs(i, t_hs, waits);
    endtask

    task automatic idle(input int i);
        s_tvalid[i] = 1'b0;
        s_tdata[i]  = '0;
        s_tlast[i]  = 1'b0;
        s_tuser[i]  = '0;
    endtask

    task automatic wait_drain(input int i);
        for (int t = 0; t < 400 && exp_q[i].size() != 0; t++) @(negedge clk);
        check($sformatf("drain%0d", i), 96'(exp_q[i].size()), 96'(0));
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        longint t0;
        int     w, w_sum;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            idle(i);
            s_tkeep[i] = '0; s_tid[i] = '0; s_tdest[i] = '0;
            m_tready[i] = 1'b0;
        end
        @(negedge clk);
        check("rst_tready", 96'(s_tready[0]), 96'(0));
        check("rst_mvalid", 96'(m_tvalid[0]), 96'(0));
        check("rst_depth", 96'(st_depth[0]), 96'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_tready", 96'(s_tready[1]), 96'(1));
        @(posedge clk); #1;

        // Plain FIFO, 20 back-to-back beats, sink always ready.
        m_tready[0] = 1'b1;
        send(0, 1'b0, 1'b0, 1'b1, t0, w);
        for (int k = 1; k < 20; k++) send(0, k == 19, 1'b0, 1'b1, last_t[0], w);
        idle(0);
        wait_drain(0);
        check("latency", 96'(first_t[0] - t0), 96'(25));
        check("throughput", 96'(last_t[0] - first_t[0]), 96'(190));
        check("idle_sideband", 96'(m_tdata[0]), 96'(0));

        // Plain FIFO, stalled sink: fills at 16 beats.
        m_tready[0] = 1'b0;
        for (int k = 0; k < 16; k++) send(0, 1'b0, 1'b0, 1'b1, t0, w);
        drive(0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check("full_tready", 96'(s_tready[0]), 96'(0));
        @(negedge clk);
        check("full_depth", 96'(st_depth[0]), 96'(16));
        check("hold_valid", 96'(m_tvalid[0]), 96'(1));
        check("hold_data", 96'(m_tdata[0]), 96'(exp_q[0][0].data));
        @(posedge clk); #1;
        m_tready[0] = 1'b1;
        wait_hs(0, t0, w);
        for (int k = 17; k < 20; k++) send(0, k == 19, 1'b0, 1'b1, t0, w);
        idle(0);
        wait_drain(0);
        check("drained_depth", 96'(st_depth[0]), 96'(0));

        // Frame FIFO: nothing visible until 2 cycles after tlast.
        m_tready[1] = 1'b1;
        for (int k = 0; k < 5; k++) send(1, k == 4, 1'b0, 1'b1, t0, w);
        idle(1);
        @(negedge clk);
        check("frame_hidden0", 96'(m_tvalid[1]), 96'(0));
        check("good_pulse", 96'(st_good[1]), 96'(1));
        @(negedge clk);
        check("frame_hidden1", 96'(m_tvalid[1]), 96'(0));
        @(negedge clk);
        check("frame_visible", 96'(m_tvalid[1]), 96'(1));
        @(posedge clk); #1;
        wait_drain(1);
        check("good_cnt1", 96'(good_cnt[1]), 96'(1));

        // Frames A(3 good), B(4 bad), C(2 good): only A and C come out.
        for (int k = 0; k < 3; k++) send(1, k == 2, 1'b0, 1'b1, t0, w);
        for (int k = 0; k < 4; k++) send(1, k == 3, k == 3, 1'b0, t0, w);
        for (int k = 0; k < 2; k++) send(1, k == 1, 1'b0, 1'b1, t0, w);
        idle(1);
        wait_drain(1);
        check("bad_cnt", 96'(bad_cnt[1]), 96'(1));
        check("good_cnt3", 96'(good_cnt[1]), 96'(3));

        // Drop-when-full: second 10-beat frame does not fit and is discarded.
        m_tready[1] = 1'b0;
        w_sum = 0;
        for (int k = 0; k < 10; k++) begin send(1, k == 9, 1'b0, 1'b1, t0, w); w_sum += w; end
        for (int k = 0; k < 10; k++) begin send(1, k == 9, 1'b0, 1'b0, t0, w); w_sum += w; end
        idle(1);
        @(negedge clk);
        check("dwf_never_stall", 96'(w_sum), 96'(0));
        check("ovf_pulse", 96'(st_ovf[1]), 96'(1));
        check("dwf_depth", 96'(st_depth[1]), 96'(10));
        @(posedge clk); #1;
        m_tready[1] = 1'b1;
        wait_drain(1);
        check("ovf_cnt", 96'(ovf_cnt[1]), 96'(1));
        check("good_cnt4", 96'(good_cnt[1]), 96'(4));

        // Reset on beat 3 of a 6-beat frame; the following frame must pass intact.
        for (int k = 0; k < 3; k++) send(1, 1'b0, 1'b0, 1'b0, t0, w);
        drive(1, 1'b0, 1'b0, 1'b0);
        #1 rst = 1'b1;
        idle(1);
        @(negedge clk);
        check("mid_rst_tready", 96'(s_tready[1]), 96'(0));
        check("mid_rst_mvalid", 96'(m_tvalid[1]), 96'(0));
        check("mid_rst_mdata", 96'(m_tdata[1]), 96'(0));
        check("mid_rst_depth", 96'(st_depth[1]), 96'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("after_rst_depth", 96'(st_depth[1]), 96'(0));
        @(posedge clk); #1;
        for (int k = 0; k < 6; k++) send(1, k == 5, 1'b0, 1'b1, t0, w);
        idle(1);
        wait_drain(1);
        check("good_cnt5", 96'(good_cnt[1]), 96'(5));
        check("final_depth", 96'(st_depth[1]), 96'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
